// File: rtl/instructions_if.sv
// Fetch/program-load bus for the instruction store.
// The master drives the fetch address and load port. The slave (the store)
// drives the fetched word, the range flag and the fetch register.
interface instructions_if #(
    parameter int ADDR_W = 8
);
    logic [31:0]       pc;
    logic [15:0]       instruction;
    logic              pc_oob;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [15:0]       wdata;
    logic              fetch_en;
    logic [15:0]       instr_q;

    modport master (
        output pc, we, waddr, wdata, fetch_en,
        input  instruction, pc_oob, instr_q
    );

    modport slave (
        input  pc, we, waddr, wdata, fetch_en,
        output instruction, pc_oob, instr_q
    );
endinterface

// File: rtl/instructions.sv
// Instruction store with a combinational fetch port, a program-load write
// port and a registered (IF/ID-style) copy of the fetched word.
// The array itself is never cleared; only the fetch register sees reset.
module instructions #(
    parameter int          DEPTH    = 256,
    parameter int          ADDR_W   = 8,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic          clk,
    input  logic          reset,
    instructions_if.slave bus
);

    logic [15:0] instruction_set [DEPTH];
    logic [15:0] instr_q_q;
    logic [15:0] instr_q_d;
    logic        pc_in_range;

    // Upper pc bits flag out-of-range; they never wrap back into the array.
    assign bus.pc_oob  = |bus.pc[31:ADDR_W];
    assign pc_in_range = (bus.pc < 32'(DEPTH));

    // Zero-latency read; depends only on pc and array contents.
    assign bus.instruction = pc_in_range ? instruction_set[bus.pc[ADDR_W-1:0]]
                                         : NOP_WORD;

    // Program-load write; blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (!reset && bus.we) begin
            instruction_set[bus.waddr] <= bus.wdata;
        end
    end

    // Fetch register next value: capture when enabled, otherwise stall.
    always_comb begin
        instr_q_d = instr_q_q;
        if (bus.fetch_en) begin
            instr_q_d = bus.instruction;
        end
    end

    // Fetch register; reset forces the NOP word immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q_q <= NOP_WORD;
        end else begin
            instr_q_q <= instr_q_d;
        end
    end

    assign bus.instr_q = instr_q_q;

endmodule

// File: tb/tb_instructions.sv
// Scoreboarded bench for the instruction store: stimulus pushes expected
// values from a plain array model, a monitor pops and compares them.
module tb_instructions;

    localparam int DEPTH = 256;

    typedef enum int {K_INSTR, K_OOB, K_Q} kind_t;

    typedef struct {
        kind_t       kind;
        logic [15:0] exp;
        string       name;
    } sb_item_t;

    logic clk;
    logic reset;

    instructions_if #(.ADDR_W(8)) bus ();

    instructions #(.DEPTH(DEPTH), .ADDR_W(8), .NOP_WORD(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    sb_item_t    sb[$];
    event        sample_ev;
    int          n_vec;
    int          n_err;

    logic [15:0] mem_m [DEPTH];
    logic [15:0] q_m;

    function automatic logic [15:0] model_instr(logic [31:0] p);
        if (p < DEPTH) return mem_m[p[7:0]];
        return 16'h0000;
    endfunction

    function automatic logic model_oob(logic [31:0] p);
        return p >= DEPTH;
    endfunction

    task automatic push(kind_t k, logic [15:0] e, string nm);
        sb_item_t it;
        it.kind = k;
        it.exp  = e;
        it.name = nm;
        sb.push_back(it);
    endtask

    // Push expectations for the current pc and the fetch register.
    task automatic expect_all(string nm);
        push(K_INSTR, model_instr(bus.pc), {nm, ".instr"});
        push(K_OOB, {15'b0, model_oob(bus.pc)}, {nm, ".oob"});
        push(K_Q, q_m, {nm, ".q"});
    endtask

    task automatic sample();
        #1;
        ->sample_ev;
        #1;
    endtask

    // One clock cycle; the model applies the same edge semantics from rules.
    task automatic tick();
        logic [15:0] pre;
        pre = model_instr(bus.pc);
        clk = 1'b1;
        if (!reset) begin
            if (bus.fetch_en) q_m = pre;
            if (bus.we) mem_m[bus.waddr] = bus.wdata;
        end
        #5;
        clk = 1'b0;
        #5;
    endtask

    // Monitor: drains the scoreboard whenever a sample point is signalled.
    initial begin
        sb_item_t    it;
        logic [15:0] act;
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                it = sb.pop_front();
                case (it.kind)
                    K_INSTR: act = bus.instruction;
                    K_OOB:   act = {15'b0, bus.pc_oob};
                    default: act = bus.instr_q;
                endcase
                n_vec++;
                if (act !== it.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] init_words [5];
        n_vec = 0;
        n_err = 0;
        init_words[0] = 16'h1001;
        init_words[1] = 16'h2002;
        init_words[2] = 16'h3003;
        init_words[3] = 16'h4004;
        init_words[4] = 16'h5005;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 16'hxxxx;

        clk          = 1'b0;
        reset        = 1'b1;
        bus.pc       = 32'd0;
        bus.we       = 1'b0;
        bus.waddr    = 8'd0;
        bus.wdata    = 16'h0;
        bus.fetch_en = 1'b0;
        q_m          = 16'h0000;
        sample();
        push(K_Q, 16'h0000, "reset_q");
        sample();

        // Program load through the write port; random fill beyond word 4.
        reset = 1'b0;
        #3;
        bus.we = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.waddr = 8'(i);
            bus.wdata = (i < 5) ? init_words[i] : 16'($urandom);
            tick();
        end
        bus.we = 1'b0;
        push(K_Q, 16'h0000, "load_no_fetch_q");
        sample();

        // Clockless reads of the preloaded words.
        for (int i = 0; i < 5; i++) begin
            bus.pc = 32'(i);
            #5;
            push(K_INSTR, init_words[i], $sformatf("preload_w%0d", i));
            push(K_OOB, 16'h0000, $sformatf("preload_oob%0d", i));
            sample();
        end

        // Out-of-range fetches, including one that would alias to word 3.
        bus.pc = 32'd256;
        sample();
        push(K_INSTR, 16'h0000, "oob256_instr");
        push(K_OOB, 16'h0001, "oob256_flag");
        sample();
        bus.pc = 32'h0001_0003;
        sample();
        push(K_INSTR, 16'h0000, "oob_alias_instr");
        push(K_OOB, 16'h0001, "oob_alias_flag");
        sample();

        // Same-edge write and fetch to one address: register gets old data.
        bus.pc       = 32'd2;
        bus.we       = 1'b1;
        bus.waddr    = 8'd2;
        bus.wdata    = 16'hABCD;
        bus.fetch_en = 1'b1;
        tick();
        bus.we = 1'b0;
        push(K_Q, 16'h3003, "rw_same_q");
        push(K_INSTR, 16'hABCD, "rw_same_instr");
        sample();

        // Capture then stall.
        bus.pc       = 32'd1;
        bus.fetch_en = 1'b1;
        tick();
        push(K_Q, 16'h2002, "fetch_w1_q");
        sample();
        bus.fetch_en = 1'b0;
        bus.pc       = 32'd4;
        tick();
        push(K_Q, 16'h2002, "stall_q");
        push(K_INSTR, 16'h5005, "stall_instr");
        sample();

        // Asynchronous reset between edges; writes blocked while asserted.
        reset = 1'b1;
        q_m   = 16'h0000;
        sample();
        push(K_Q, 16'h0000, "async_reset_q");
        sample();
        bus.pc       = 32'd1;
        bus.we       = 1'b1;
        bus.waddr    = 8'd1;
        bus.wdata    = 16'hFFFF;
        bus.fetch_en = 1'b1;
        tick();
        push(K_INSTR, 16'h2002, "reset_blocks_write");
        push(K_Q, 16'h0000, "reset_blocks_fetch");
        sample();
        bus.pc = 32'd3;
        sample();
        push(K_INSTR, 16'h4004, "reset_read_follows_pc");
        sample();
        bus.we = 1'b0;
        reset  = 1'b0;
        tick();
        push(K_Q, 16'h4004, "first_fetch_after_reset");
        sample();

        // Randomized traffic against the array model.
        for (int n = 0; n < 300; n++) begin
            bus.pc       = ($urandom_range(0, 7) == 0) ? $urandom
                                                       : 32'($urandom_range(0, DEPTH - 1));
            bus.we       = 1'($urandom);
            bus.waddr    = ($urandom_range(0, 3) == 0) ? bus.pc[7:0] : 8'($urandom);
            bus.wdata    = 16'($urandom);
            bus.fetch_en = 1'($urandom);
            sample();
            expect_all($sformatf("rnd%0d_pre", n));
            sample();
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                q_m   = 16'h0000;
                sample();
                expect_all($sformatf("rnd%0d_rst", n));
                sample();
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
            expect_all($sformatf("rnd%0d_post", n));
            sample();
        end

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
